// File: rtl/led_share_arbiter.sv
// Round-robin share of eight active-low LEDs among three requesters: one LED
// lit for HOLD_CYCLES cycles per grant, then one blank cycle before the next grant.
module led_share_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [2:0]       idx0,
  input  logic [2:0]       idx1,
  input  logic [2:0]       idx2,
  output logic [2:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic [7:0]       led
);

  localparam int NUM_REQ = 3;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic             win_vld;
  logic [1:0]       win;
  logic [2:0]       win_idx;

  // Scan from the farthest slot back to ptr so the slot nearest ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win     = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int pos;
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (req[pos]) begin
        win_vld = 1'b1;
        win     = 2'(pos);
      end
    end
  end

  always_comb begin
    win_idx = idx0;
    case (win)
      2'd1:    win_idx = idx1;
      2'd2:    win_idx = idx2;
      default: win_idx = idx0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= 2'd0;
      gnt   <= 3'b000;
      busy  <= 1'b0;
      done  <= 1'b0;
      led   <= 8'hff;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (win_vld) begin
            gnt   <= 3'b001 << win;
            led   <= ~(8'd1 << win_idx);
            cnt   <= CNT_W'(HOLD_CYCLES - 1);
            busy  <= 1'b1;
            state <= SHOW;
          end
        end
        SHOW: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // The held one-hot grant still names the winner; rotate past it.
            ptr   <= gnt[2] ? 2'd0 : (gnt[1] ? 2'd2 : 2'd1);
            gnt   <= 3'b000;
            led   <= 8'hff;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/led_share_arbiter.md
Name: led_share_arbiter

Overview:
- Shares the board's 8 active-low LEDs among three requesters, one requester at a time.
- Each requester asks to light one LED index. A round-robin arbiter picks one request, lights that LED alone for a fixed hold time, then blanks all LEDs for one cycle before the next grant.
- Sits between the client blocks and the LED pins. It replaces direct one-hot LED decoding when more than one source needs the display.

Parameters:
- HOLD_CYCLES, 4, number of clk cycles a granted LED stays lit; legal range 1..255 (0 illegal).
- CNT_W, 8, width of the hold counter; must hold HOLD_CYCLES-1.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, synchronous and active-high (one clock; polarity and synchronicity fixed).
- req  input  3  req[i]=1: requester i wants the display; must stay high until gnt[i] is seen.
- idx0  input  3  LED index for requester 0; sampled only at grant.
- idx1  input  3  LED index for requester 1; sampled only at grant.
- idx2  input  3  LED index for requester 2; sampled only at grant.
- gnt  output  3  one-hot grant; high for the whole hold window.
- busy  output  1  high while in SHOW.
- done  output  1  one-cycle pulse on the cycle after the hold window ends.
- led  output  8  active-low LED drive; 8'hff = all off.

Behaviour:
- Reset (rst=1 at posedge) gives, from the next cycle on:
  - led=8'hff, gnt=3'b000, busy=0, done=0;
  - state=IDLE, hold counter=0, priority pointer ptr=0.
  - Reset wins over every other event, including mid-SHOW; the lit LED is blanked at that edge.
- States: IDLE, SHOW.
- IDLE, req==0: outputs hold at reset values, except done, which may be high for exactly the first IDLE cycle after SHOW.
- IDLE, req!=0 at a posedge:
  - Winner = first set bit of req scanning ptr, ptr+1, ptr+2 (mod 3).
  - At that same edge: gnt<=onehot(winner), led<=8'hff - (8'd1<<idx_winner), cnt<=HOLD_CYCLES-1, busy<=1, state<=SHOW.
  - Latency: req sampled at edge k gives gnt/led valid right after edge k (zero idle cycles).
- SHOW, cnt!=0: cnt<=cnt-1; led and gnt hold.
- SHOW, cnt==0 at an edge:
  - gnt<=0, led<=8'hff, busy<=0, done<=1, ptr<=(winner+1) mod 3, state<=IDLE.
- done drops at the following edge.
- LED lit exactly HOLD_CYCLES cycles per grant.
- At least one all-off cycle between grants; IDLE cannot grant on the edge that leaves SHOW.
- In SHOW: req changes are ignored (no abort, no preemption); idx changes are ignored (index latched at grant).
- A requester still asserting req after its grant ends is re-arbitrated normally. With ptr rotation it gets lowest priority next round.
- Exactly one LED bit is low whenever busy=1; led=8'hff whenever busy=0.
- Index arithmetic: 3-bit idx maps to bit 0..7 of led; no out-of-range case.
- ptr wraps 2→0.
- If rst is high in the same cycle as a grant condition, reset wins and no grant occurs.

Test Plan:
- rst=1 for 2 cycles, then req=000 for 5 cycles → led=8'hff, gnt=000, busy=0, done=0 throughout.
- HOLD_CYCLES=4, req=001, idx0=3 at edge k → led=8'hf7, gnt=001 for edges k..k+3; at edge k+4: led=8'hff, gnt=000, done=1 for one cycle.
- req=111 held with idx0=0, idx1=5, idx2=7 → grants in order 0,1,2,0, with led 8'hfe, 8'hdf, 8'h7f, 8'hfe. Each window is 4 cycles, separated by exactly one 8'hff cycle.
- After granting requester 1, assert req=101 → requester 2 granted next (ptr=2), then requester 0.
- Grant requester 0 with idx0=2, then change idx0 to 6 and drop req during SHOW → led stays 8'hfb for the full 4 cycles; no abort.
- Assert rst at the 2nd cycle of a SHOW window → next cycle led=8'hff, gnt=000, busy=0, done=0. First grant after reset goes to requester 0 when req=111.
